// File: rtl/spart_bus_arbiter_if.sv
// Requester-side handshake bundle for spart_bus_arbiter.
// master: requesters drive req*, see gnt/done/err/rdata; slave: arbiter.
interface spart_bus_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_rw;
  logic [2*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic                 err;
  logic [7:0]           rdata;

  modport master (
    output req, req_rw, req_addr, req_wdata,
    input  gnt, done, err, rdata
  );

  modport slave (
    input  req, req_rw, req_addr, req_wdata,
    output gnt, done, err, rdata
  );
endinterface

// File: rtl/spart_bus_arbiter.sv
// Round-robin arbiter sharing the SPART processor bus between requesters.
// Ports: clk, rst_n, rq (requester if), iocs/iorw/ioaddr/databus, rda/tbr.
module spart_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  spart_bus_arbiter_if.slave  rq,
  output logic                iocs,
  output logic                iorw,
  output logic [1:0]          ioaddr,
  inout  wire  [7:0]          databus,
  input  logic                rda,
  input  logic                tbr
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RDY,
    XFER,
    DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   win;
  logic               rw_q;
  logic [1:0]         addr_q;
  logic [7:0]         wdata_q;
  logic [CNT_W-1:0]   cnt;
  logic               abort;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic               err_q;
  logic [7:0]         rdata_q;
  logic               iocs_q;
  logic               iorw_q;
  logic [1:0]         ioaddr_q;
  logic               oe;

  logic [IDX_W-1:0]   pick;
  logic               found;
  int                 j;
  logic               rdy;

  // First set request after the previous winner, wrapping around.
  always_comb begin
    pick  = last;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(last) + k) % NUM_REQ;
      if (!found && rq.req[j]) begin
        found = 1'b1;
        pick  = IDX_W'(j);
      end
    end
  end

  // Only the RX/TX buffer register has to wait for the link.
  always_comb begin
    rdy = 1'b1;
    if (addr_q == 2'b00)
      rdy = rw_q ? rda : tbr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= IDX_W'(NUM_REQ - 1);
      win      <= '0;
      rw_q     <= 1'b1;
      addr_q   <= 2'b00;
      wdata_q  <= 8'h00;
      cnt      <= '0;
      abort    <= 1'b0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      rdata_q  <= 8'h00;
      iocs_q   <= 1'b0;
      iorw_q   <= 1'b1;
      ioaddr_q <= 2'b00;
      oe       <= 1'b0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            win     <= pick;
            rw_q    <= rq.req_rw[pick];
            addr_q  <= rq.req_addr[2*pick +: 2];
            wdata_q <= rq.req_wdata[8*pick +: 8];
            gnt_q   <= NUM_REQ'(1) << pick;
            cnt     <= '0;
            abort   <= 1'b0;
            state   <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (rdy) begin
            iocs_q   <= 1'b1;
            iorw_q   <= rw_q;
            ioaddr_q <= addr_q;
            oe       <= ~rw_q;
            state    <= XFER;
          end else if (TO_EN && cnt == TMAX) begin
            abort  <= 1'b1;
            done_q <= gnt_q;
            err_q  <= 1'b1;
            state  <= DONE;
          end else if (cnt != TMAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        XFER: begin
          iocs_q   <= 1'b0;
          iorw_q   <= 1'b1;
          ioaddr_q <= 2'b00;
          oe       <= 1'b0;
          if (rw_q)
            rdata_q <= databus;
          done_q <= gnt_q;
          err_q  <= abort;
          state  <= DONE;
        end
        DONE: begin
          gnt_q <= '0;
          last  <= win;
          cnt   <= '0;
          abort <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign databus  = oe ? wdata_q : 8'hzz;
  assign iocs     = iocs_q;
  assign iorw     = iorw_q;
  assign ioaddr   = ioaddr_q;
  assign rq.gnt   = gnt_q;
  assign rq.done  = done_q;
  assign rq.err   = err_q;
  assign rq.rdata = rdata_q;

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Scoreboard bench for spart_bus_arbiter (two instances: long/short timeout).
// Stimulus pushes expected bus cycles and completions; a monitor checks.
module tb_spart_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rda = 1'b0;
  logic tbr = 1'b0;
  logic [7:0] tbd = 8'h00;
  logic tbe = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0] rd_a = 8'h00;
  logic [7:0] rd_b = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spart_bus_arbiter_if #(.NUM_REQ(2)) ia ();
  spart_bus_arbiter_if #(.NUM_REQ(2)) ib ();

  logic iocs_a, iorw_a, iocs_b, iorw_b;
  logic [1:0] ioaddr_a, ioaddr_b;
  wire [7:0] db_a, db_b;
  assign db_a = tbe ? tbd : 8'hzz;
  assign db_b = tbe ? tbd : 8'hzz;

  spart_bus_arbiter #(
    .NUM_REQ(2), .TIMEOUT(1024), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .rq(ia),
    .iocs(iocs_a), .iorw(iorw_a), .ioaddr(ioaddr_a),
    .databus(db_a), .rda(rda), .tbr(tbr)
  );

  spart_bus_arbiter #(
    .NUM_REQ(2), .TIMEOUT(8), .CNT_W(16)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .rq(ib),
    .iocs(iocs_b), .iorw(iorw_b), .ioaddr(ioaddr_b),
    .databus(db_b), .rda(rda), .tbr(tbr)
  );

  typedef struct {
    int         cyc;
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
  } xexp_t;

  typedef struct {
    int         cyc;
    int         idx;
    logic       err;
    logic [7:0] rd;
  } dexp_t;

  xexp_t xq_a[$], xq_b[$];
  dexp_t dq_a[$], dq_b[$];

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic void mon_x(input int inst, input logic cs,
                                input logic rw, input logic [1:0] a,
                                input logic [7:0] d);
    xexp_t e;
    int n;
    if (!cs) return;
    n = (inst == 0) ? xq_a.size() : xq_b.size();
    checks++;
    if (n == 0) begin
      errors++;
      $display("FAIL xfer_unexpected: inst %0d got iocs=1 expected none",
               inst);
      return;
    end
    if (inst == 0) e = xq_a.pop_front();
    else e = xq_b.pop_front();
    chk("xfer_cycle", cyc, e.cyc);
    chk("xfer_iorw", int'(rw), int'(e.rw));
    chk("xfer_ioaddr", int'(a), int'(e.addr));
    chk("xfer_databus", int'(d), int'(e.data));
  endfunction

  function automatic void mon_d(input int inst, input logic [1:0] dn,
                                input logic [1:0] g, input logic er,
                                input logic [7:0] rd);
    dexp_t e;
    int n;
    if (dn == 2'b00) return;
    n = (inst == 0) ? dq_a.size() : dq_b.size();
    checks++;
    if (n == 0) begin
      errors++;
      $display("FAIL done_unexpected: inst %0d got done=%b expected none",
               inst, dn);
      return;
    end
    if (inst == 0) e = dq_a.pop_front();
    else e = dq_b.pop_front();
    chk("done_cycle", cyc, e.cyc);
    chk("done_onehot", int'(dn), 1 << e.idx);
    chk("done_gnt", int'(g), 1 << e.idx);
    chk("done_err", int'(er), int'(e.err));
    chk("done_rdata", int'(rd), int'(e.rd));
  endfunction

  always @(negedge clk) begin
    mon_x(0, iocs_a, iorw_a, ioaddr_a, db_a);
    mon_x(1, iocs_b, iorw_b, ioaddr_b, db_b);
    mon_d(0, ia.done, ia.gnt, ia.err, ia.rdata);
    mon_d(1, ib.done, ib.gnt, ib.err, ib.rdata);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (i < 200 && (dq_a.size() + dq_b.size() != 0)) begin
      tick(1);
      i++;
    end
    chk("drain_pending", dq_a.size() + dq_b.size(), 0);
    tick(1);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_gnt"}, int'(ia.gnt), 0);
    chk({tag, "_done"}, int'(ia.done), 0);
    chk({tag, "_err"}, int'(ia.err), 0);
    chk({tag, "_rdata"}, int'(ia.rdata), 0);
    chk({tag, "_iocs"}, int'(iocs_a), 0);
    chk({tag, "_iorw"}, int'(iorw_a), 1);
    chk({tag, "_ioaddr"}, int'(ioaddr_a), 0);
  endtask

  int c0;

  initial begin
    ia.req = '0; ia.req_rw = '0; ia.req_addr = '0; ia.req_wdata = '0;
    ib.req = '0; ib.req_rw = '0; ib.req_addr = '0; ib.req_wdata = '0;
    tick(2);
    chk_reset_a("reset");
    rst_n = 1'b1;
    tick(1);

    // Write to DB low from requester 0
    c0 = cyc;
    xq_a.push_back('{c0 + 2, 1'b0, 2'b10, 8'h80});
    dq_a.push_back('{c0 + 3, 0, 1'b0, rd_a});
    ia.req = 2'b01; ia.req_rw = 2'b00;
    ia.req_addr = 4'b0010; ia.req_wdata = 16'h0080;
    tick(1);
    chk("t1_gnt_early", int'(ia.gnt), 1);
    ia.req = 2'b00; ia.req_wdata = 16'hffff; ia.req_addr = 4'b1111;
    drain();

    // RX read held off by rda for 20 cycles
    c0 = cyc;
    xq_a.push_back('{c0 + 21, 1'b1, 2'b00, 8'h5a});
    rd_a = 8'h5a;
    dq_a.push_back('{c0 + 22, 1, 1'b0, rd_a});
    ia.req = 2'b10; ia.req_rw = 2'b10; ia.req_addr = 4'b0000;
    tick(1);
    ia.req = 2'b00;
    tick(19);
    rda = 1'b1; tbd = 8'h5a; tbe = 1'b1;
    tick(2);
    rda = 1'b0;
    drain();
    tbe = 1'b0;

    // Round robin between two continuous writers
    tbr = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      xq_a.push_back('{c0 + 2 + 4*k, 1'b0, 2'b00,
                       (k % 2 == 0) ? 8'h11 : 8'h22});
      dq_a.push_back('{c0 + 3 + 4*k, k % 2, 1'b0, rd_a});
    end
    ia.req = 2'b11; ia.req_rw = 2'b00;
    ia.req_addr = 4'b0000; ia.req_wdata = 16'h2211;
    tick(13);
    ia.req = 2'b00;
    drain();
    tbr = 1'b0;

    // Short-timeout instance: rda arrives on the last allowed cycle
    c0 = cyc;
    xq_b.push_back('{c0 + 9, 1'b1, 2'b00, 8'hc3});
    rd_b = 8'hc3;
    dq_b.push_back('{c0 + 10, 0, 1'b0, rd_b});
    ib.req = 2'b01; ib.req_rw = 2'b01; ib.req_addr = 4'b0000;
    tick(1);
    ib.req = 2'b00;
    tick(7);
    rda = 1'b1; tbd = 8'hc3; tbe = 1'b1;
    tick(2);
    rda = 1'b0;
    drain();
    tbe = 1'b0;

    // Timeout on TX write with tbr stuck low; rdata must hold
    c0 = cyc;
    dq_b.push_back('{c0 + 9, 0, 1'b1, rd_b});
    ib.req = 2'b01; ib.req_rw = 2'b00;
    ib.req_addr = 4'b0000; ib.req_wdata = 16'h0033;
    tick(1);
    ib.req = 2'b00;
    drain();

    // Next request on the same instance is served normally
    c0 = cyc;
    xq_b.push_back('{c0 + 2, 1'b0, 2'b01, 8'h44});
    dq_b.push_back('{c0 + 3, 0, 1'b0, rd_b});
    ib.req = 2'b01; ib.req_rw = 2'b00;
    ib.req_addr = 4'b0001; ib.req_wdata = 16'h0044;
    tick(1);
    ib.req = 2'b00;
    drain();

    // Reset while waiting for tbr abandons the transaction
    c0 = cyc;
    ia.req = 2'b10; ia.req_rw = 2'b00; ia.req_addr = 4'b0000;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    rd_a = 8'h00;
    rd_b = 8'h00;
    chk_reset_a("midrst");

    // After release requester 0 wins first
    rst_n = 1'b1;
    c0 = cyc;
    xq_a.push_back('{c0 + 2, 1'b0, 2'b01, 8'h55});
    dq_a.push_back('{c0 + 3, 0, 1'b0, rd_a});
    xq_a.push_back('{c0 + 6, 1'b0, 2'b01, 8'h66});
    dq_a.push_back('{c0 + 7, 1, 1'b0, rd_a});
    ia.req = 2'b11; ia.req_rw = 2'b00;
    ia.req_addr = 4'b0101; ia.req_wdata = 16'h6655;
    tick(5);
    ia.req = 2'b00;
    drain();

    chk("xfer_pending", xq_a.size() + xq_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
